// File: rtl/sprite_pkg.sv
// Shared keycodes, mode/state encodings and direction type for the sprite motion engine.
package sprite_pkg;

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    typedef enum logic {BOUNCE = 1'b0, CLAMP = 1'b1} mode_e;
    typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_e;

    typedef logic signed [1:0] dir_t;

    localparam dir_t DIR_NEG  = -2'sd1;
    localparam dir_t DIR_ZERO = 2'sd0;
    localparam dir_t DIR_POS  = 2'sd1;

endpackage

// File: rtl/sprite_axis.sv
// One motion axis: registered position and hit pulse, with bounce/clamp edge resolution.
module sprite_axis
    import sprite_pkg::*;
#(
    parameter int    MIN    = 0,
    parameter int    MAX    = 639,
    parameter int    CENTER = 320,
    parameter int    SIZE   = 16,
    parameter mode_e MODE   = BOUNCE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic signed [1:0] d,
    input  logic [3:0]        speed,
    output logic [9:0]        pos,
    output logic              hit,
    output logic signed [1:0] d_next
);

    localparam logic signed [11:0] LO = 12'(MIN + SIZE);
    localparam logic signed [11:0] HI = 12'(MAX - SIZE);

    logic signed [11:0] vel;
    logic signed [11:0] next;
    logic [9:0]         pos_nxt;
    logic               hit_nxt;

    always_comb begin
        vel = '0;
        if (d == DIR_POS)
            vel = $signed({8'b0, speed});
        else if (d == DIR_NEG)
            vel = -$signed({8'b0, speed});

        next    = $signed({2'b00, pos}) + vel;
        pos_nxt = pos;
        hit_nxt = 1'b0;
        d_next  = d;

        // Edge tests compare the centre against the inset band, so MIN = 0 never wraps.
        if (enable) begin
            if (next > HI) begin
                pos_nxt = HI[9:0];
                hit_nxt = 1'b1;
                d_next  = (MODE == BOUNCE) ? DIR_NEG : DIR_ZERO;
            end else if (next < LO) begin
                pos_nxt = LO[9:0];
                hit_nxt = 1'b1;
                d_next  = (MODE == BOUNCE) ? DIR_POS : DIR_ZERO;
            end else begin
                pos_nxt = next[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= 10'(CENTER);
            hit <= 1'b0;
        end else begin
            pos <= pos_nxt;
            hit <= hit_nxt;
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Keyboard-steered sprite: key edge detect, speed/direction state, RUN/PAUSED FSM, two axes.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int X_CENTER  = 320,
    parameter int Y_CENTER  = 240,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int SIZE      = 16,
    parameter int MAX_SPEED = 4,
    parameter int MODE      = 0
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic [9:0] SpriteX,
    output logic [9:0] SpriteY,
    output logic [9:0] SpriteS,
    output logic [3:0] Speed,
    output logic       Paused,
    output logic       HitX,
    output logic       HitY
);

    localparam mode_e AXIS_MODE = (MODE == 1) ? CLAMP : BOUNCE;

    state_e     state, state_next;
    logic [7:0] prev_key;
    dir_t       dx, dy;
    dir_t       dx_key, dy_key;
    dir_t       dx_next, dy_next;
    logic [3:0] speed_next;
    logic       key_event;
    logic       space_event;
    logic       move;

    assign key_event   = (keycode != 8'h00) && (keycode != prev_key);
    assign space_event = key_event && (keycode == KEY_SPACE);

    always_comb begin
        state_next = state;
        dx_key     = dx;
        dy_key     = dy;
        speed_next = Speed;
        move       = 1'b0;

        unique case (state)
            RUN: begin
                if (space_event) begin
                    state_next = PAUSED;
                end else begin
                    move = 1'b1;
                    // A key matching the current heading speeds up; any other heading turns.
                    if (key_event) begin
                        case (keycode)
                            KEY_RIGHT: begin
                                if (dx == DIR_POS) speed_next = (Speed < 4'(MAX_SPEED)) ? Speed + 4'd1 : Speed;
                                else begin dx_key = DIR_POS; dy_key = DIR_ZERO; end
                            end
                            KEY_LEFT: begin
                                if (dx == DIR_NEG) speed_next = (Speed < 4'(MAX_SPEED)) ? Speed + 4'd1 : Speed;
                                else begin dx_key = DIR_NEG; dy_key = DIR_ZERO; end
                            end
                            KEY_DOWN: begin
                                if (dy == DIR_POS) speed_next = (Speed < 4'(MAX_SPEED)) ? Speed + 4'd1 : Speed;
                                else begin dy_key = DIR_POS; dx_key = DIR_ZERO; end
                            end
                            KEY_UP: begin
                                if (dy == DIR_NEG) speed_next = (Speed < 4'(MAX_SPEED)) ? Speed + 4'd1 : Speed;
                                else begin dy_key = DIR_NEG; dx_key = DIR_ZERO; end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PAUSED: begin
                if (space_event) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state    <= RUN;
            prev_key <= '0;
            dx       <= DIR_POS;
            dy       <= DIR_ZERO;
            Speed    <= 4'd1;
        end else begin
            state    <= state_next;
            prev_key <= keycode;
            dx       <= dx_next;
            dy       <= dy_next;
            Speed    <= speed_next;
        end
    end

    sprite_axis #(
        .MIN    (X_MIN),
        .MAX    (X_MAX),
        .CENTER (X_CENTER),
        .SIZE   (SIZE),
        .MODE   (AXIS_MODE)
    ) u_axis_x (
        .clk    (frame_clk),
        .reset  (Reset),
        .enable (move),
        .d      (dx_key),
        .speed  (speed_next),
        .pos    (SpriteX),
        .hit    (HitX),
        .d_next (dx_next)
    );

    sprite_axis #(
        .MIN    (Y_MIN),
        .MAX    (Y_MAX),
        .CENTER (Y_CENTER),
        .SIZE   (SIZE),
        .MODE   (AXIS_MODE)
    ) u_axis_y (
        .clk    (frame_clk),
        .reset  (Reset),
        .enable (move),
        .d      (dy_key),
        .speed  (speed_next),
        .pos    (SpriteY),
        .hit    (HitY),
        .d_next (dy_next)
    );

    assign SpriteS = 10'(SIZE);
    assign Paused  = (state == PAUSED);

endmodule

// File: tb/tb_sprite_mover.sv
// Vector/scoreboard bench: a bounce-mode instance at default parameters and a clamp-mode instance near the edges.
module tb_sprite_mover;

    typedef struct {
        bit         sel;
        bit         rst;
        logic [7:0] key;
        int         x;
        int         y;
        int         spd;
        bit         p;
        bit         hx;
        bit         hy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1, rst2 = 1'b1;
    logic [7:0] key1 = 8'h00, key2 = 8'h00;

    logic [9:0] x1, y1, s1, x2, y2, s2;
    logic [3:0] sp1, sp2;
    logic       p1, hx1, hy1, p2, hx2, hy2;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    sprite_mover dut_bounce (
        .frame_clk (clk), .Reset (rst1), .keycode (key1),
        .SpriteX (x1), .SpriteY (y1), .SpriteS (s1), .Speed (sp1),
        .Paused (p1), .HitX (hx1), .HitY (hy1)
    );

    sprite_mover #(
        .X_CENTER (617),
        .Y_CENTER (461),
        .MODE     (1)
    ) dut_clamp (
        .frame_clk (clk), .Reset (rst2), .keycode (key2),
        .SpriteX (x2), .SpriteY (y2), .SpriteS (s2), .Speed (sp2),
        .Paused (p2), .HitX (hx2), .HitY (hy2)
    );

    task automatic check(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    function automatic void add(input bit sel, input bit rst, input logic [7:0] key,
                                input int x, input int y, input int spd,
                                input bit p, input bit hx, input bit hy);
        vec_t v;
        v.sel = sel; v.rst = rst; v.key = key; v.x = x; v.y = y; v.spd = spd;
        v.p = p; v.hx = hx; v.hy = hy;
        vecs.push_back(v);
    endfunction

    vec_t table0[42] = '{
        '{0,1,8'h00,320,240,1,0,0,0}, '{0,1,8'h00,320,240,1,0,0,0},
        '{0,0,8'h00,321,240,1,0,0,0}, '{0,0,8'h00,322,240,1,0,0,0},
        '{0,0,8'h00,323,240,1,0,0,0},
        '{0,1,8'h00,320,240,1,0,0,0},
        '{0,0,8'h07,322,240,2,0,0,0}, '{0,0,8'h07,324,240,2,0,0,0},
        '{0,0,8'h07,326,240,2,0,0,0}, '{0,0,8'h00,328,240,2,0,0,0},
        '{0,0,8'h07,331,240,3,0,0,0}, '{0,0,8'h00,334,240,3,0,0,0},
        '{0,0,8'h07,338,240,4,0,0,0}, '{0,0,8'h00,342,240,4,0,0,0},
        '{0,0,8'h07,346,240,4,0,0,0}, '{0,0,8'h00,350,240,4,0,0,0},
        '{0,0,8'h07,354,240,4,0,0,0}, '{0,0,8'h00,358,240,4,0,0,0},
        '{0,0,8'h07,362,240,4,0,0,0}, '{0,0,8'h00,366,240,4,0,0,0},
        '{0,0,8'h07,370,240,4,0,0,0}, '{0,0,8'h00,374,240,4,0,0,0},
        '{0,0,8'h07,378,240,4,0,0,0},
        '{0,0,8'h2C,378,240,4,1,0,0}, '{0,0,8'h2C,378,240,4,1,0,0},
        '{0,0,8'h00,378,240,4,1,0,0}, '{0,0,8'h04,378,240,4,1,0,0},
        '{0,0,8'h04,378,240,4,1,0,0}, '{0,0,8'h00,378,240,4,1,0,0},
        '{0,0,8'h00,378,240,4,1,0,0}, '{0,0,8'h00,378,240,4,1,0,0},
        '{0,0,8'h00,378,240,4,1,0,0}, '{0,0,8'h00,378,240,4,1,0,0},
        '{0,0,8'h2C,378,240,4,0,0,0}, '{0,0,8'h00,382,240,4,0,0,0},
        '{0,0,8'h2C,382,240,4,1,0,0},
        '{0,1,8'h00,320,240,1,0,0,0}, '{0,0,8'h00,321,240,1,0,0,0},
        '{0,0,8'h2C,321,240,1,1,0,0}, '{0,0,8'h00,321,240,1,1,0,0},
        '{0,0,8'h2C,321,240,1,0,0,0}, '{0,0,8'h00,322,240,1,0,0,0}
    };

    initial begin
        vec_t e;
        vec_t v;
        int   idx;

        foreach (table0[i]) vecs.push_back(table0[i]);

        // Bounce instance: accelerate to speed 4 and run into the right edge, then the left edge.
        add(0,1,8'h00,320,240,1,0,0,0);
        add(0,0,8'h00,321,240,1,0,0,0);
        add(0,0,8'h00,322,240,1,0,0,0);
        add(0,0,8'h07,324,240,2,0,0,0);
        add(0,0,8'h00,326,240,2,0,0,0);
        add(0,0,8'h07,329,240,3,0,0,0);
        add(0,0,8'h00,332,240,3,0,0,0);
        add(0,0,8'h07,336,240,4,0,0,0);
        for (int i = 1; i <= 71; i++) add(0,0,8'h00,336+4*i,240,4,0,0,0);
        add(0,0,8'h2C,620,240,4,1,0,0);
        add(0,0,8'h00,620,240,4,1,0,0);
        add(0,0,8'h2C,620,240,4,0,0,0);
        add(0,0,8'h00,623,240,4,0,1,0);
        for (int k = 1; k <= 151; k++) add(0,0,8'h00,623-4*k,240,4,0,0,0);
        add(0,0,8'h00,16,240,4,0,1,0);
        add(0,0,8'h00,20,240,4,0,0,0);

        // Clamp instance: key and edge on the same frame, re-hit after clamp, walk into corner, left clamp.
        add(1,1,8'h00,617,461,1,0,0,0);
        add(1,0,8'h07,619,461,2,0,0,0);
        add(1,0,8'h00,621,461,2,0,0,0);
        add(1,0,8'h07,623,461,3,0,1,0);
        add(1,0,8'h00,623,461,3,0,0,0);
        add(1,0,8'h07,623,461,3,0,1,0);
        add(1,0,8'h1A,623,458,3,0,0,0);
        add(1,0,8'h00,623,455,3,0,0,0);
        add(1,0,8'h16,623,458,3,0,0,0);
        add(1,0,8'h00,623,461,3,0,0,0);
        add(1,0,8'h00,623,463,3,0,0,1);
        add(1,0,8'h00,623,463,3,0,0,0);
        add(1,0,8'h04,620,463,3,0,0,0);
        for (int k = 1; k <= 201; k++) add(1,0,8'h00,620-3*k,463,3,0,0,0);
        add(1,0,8'h00,16,463,3,0,1,0);
        add(1,0,8'h00,16,463,3,0,0,0);

        idx = 0;
        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            if (v.sel) begin
                rst1 = 1'b1; key1 = 8'h00;
                rst2 = v.rst; key2 = v.key;
            end else begin
                rst1 = v.rst; key1 = v.key;
            end
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", idx, 16'd1, 16'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.sel) begin
                    check("x",      idx, 16'(x2),  16'(e.x));
                    check("y",      idx, 16'(y2),  16'(e.y));
                    check("size",   idx, 16'(s2),  16'd16);
                    check("speed",  idx, 16'(sp2), 16'(e.spd));
                    check("paused", idx, 16'(p2),  16'(e.p));
                    check("hitx",   idx, 16'(hx2), 16'(e.hx));
                    check("hity",   idx, 16'(hy2), 16'(e.hy));
                end else begin
                    check("x",      idx, 16'(x1),  16'(e.x));
                    check("y",      idx, 16'(y1),  16'(e.y));
                    check("size",   idx, 16'(s1),  16'd16);
                    check("speed",  idx, 16'(sp1), 16'(e.spd));
                    check("paused", idx, 16'(p1),  16'(e.p));
                    check("hitx",   idx, 16'(hx1), 16'(e.hx));
                    check("hity",   idx, 16'(hy1), 16'(e.hy));
                end
            end
            idx++;
        end

        check("scoreboard_leftover", idx, 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
